alu_share_arb: RTL

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/rr_arb2.sv | 53 +++++
 rtl/alu_share_arb.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the ALU sharing arbiter:
//   - ALU op code constants (ADD, SUB, AND, OR, XOR, ILLEGAL)
//   - arbiter FSM state enum
//   - helper that classifies an op code as illegal
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam logic [3:0] ALU_ADD     = 4'h0;
  localparam logic [3:0] ALU_SUB     = 4'h1;
  localparam logic [3:0] ALU_AND     = 4'h2;
  localparam logic [3:0] ALU_OR      = 4'h3;
  localparam logic [3:0] ALU_XOR     = 4'h4;
  localparam logic [3:0] ALU_ILLEGAL = 4'hF;

  // Highest op code the shared ALU implements; anything above is rejected.
  localparam logic [3:0] ALU_OP_MAX  = ALU_XOR;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  // 4'hF is above ALU_OP_MAX, so one compare covers both illegal cases.
  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op > ALU_OP_MAX);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester arbiter producing a one-hot (or zero) grant.
// Build option (macro ALU_ARB_RR_EN):
//   defined   : round-robin; on contention the requester not granted last
//               wins. last_grant resets to 1 so req0 wins the first contention.
//   undefined : fixed priority, req0 always wins; no state, no clock.
// Ports:
//   clk, rst   : clock / async active-high reset (round-robin build only)
//   advance    : a grant is actually being taken this cycle (round-robin only)
//   req[1:0]   : request vector
//   gnt[1:0]   : one-hot grant, subset of req
// ---------------------------------------------------------------------------
module rr_arb2
  import riscv_pkg::*;
(
`ifdef ALU_ARB_RR_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef ALU_ARB_RR_EN
  // Index of the requester granted most recently.
  logic last_grant_reg;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_grant_reg ? 2'b01 : 2'b10;
    end
  end

  // Updates on every taken grant, contended or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      last_grant_reg <= gnt[1];
    end
  end
`else
  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0];
    gnt[1] = req[1] & ~req[0];
  end
`endif

endmodule

// File: rtl/alu_share_arb.sv
// ---------------------------------------------------------------------------
// alu_share_arb
// Shares one external combinational ALU between two requesters.
// FSM: IDLE (grant + latch) -> EXEC (drive ALU, capture result) -> RESP
// (hold response until rsp_ready). Minimum issue interval is 3 cycles.
// Build option: ALU_ARB_RR_EN selects round-robin arbitration in rr_arb2,
// otherwise req0 has fixed priority.
// Ports:
//   clk, rst                      : clock, async active-high reset
//   reqN_valid/ready/op/a/b       : requester N handshake and operation
//   alu_op/alu_a/alu_b            : to shared ALU (idle: 4'hF / 0 / 0)
//   alu_result                    : from shared ALU, same cycle
//   rsp_valid/id/err/result       : response to consumer
//   rsp_ready                     : consumer accepts response
// ---------------------------------------------------------------------------
module alu_share_arb
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  output logic            rsp_valid,
  output logic            rsp_id,
  output logic            rsp_err,
  output logic [XLEN-1:0] rsp_result,
  input  logic            rsp_ready
);

  arb_state_t state_reg, state_next;

  logic [1:0]      req_vec;
  logic [1:0]      gnt;
  logic [1:0]      ready_vec;
  logic            grant_en;
  logic            take;

  logic [3:0]      op_reg;
  logic [XLEN-1:0] a_reg;
  logic [XLEN-1:0] b_reg;
  logic            id_reg;
  logic            rsp_id_reg;
  logic            err_reg;
  logic [XLEN-1:0] result_reg;
  logic            exec_illegal;

  assign req_vec = {req1_valid, req0_valid};

  // rst is folded in so ready drops the instant reset asserts, not at the
  // next edge.
  assign grant_en = (state_reg == ST_IDLE) && !rst;

  rr_arb2 u_arb (
`ifdef ALU_ARB_RR_EN
    .clk     (clk),
    .rst     (rst),
    .advance (grant_en),
`endif
    .req     (req_vec),
    .gnt     (gnt)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = grant_en & gnt[gi];
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];
  assign take       = |ready_vec;

  assign exec_illegal = is_illegal_op(op_reg);

  // Next state and FSM-driven outputs.
  always_comb begin
    state_next = state_reg;
    alu_op     = ALU_ILLEGAL;
    alu_a      = '0;
    alu_b      = '0;
    rsp_valid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (take) begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_op     = op_reg;
        alu_a      = a_reg;
        alu_b      = b_reg;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      op_reg     <= ALU_ILLEGAL;
      a_reg      <= '0;
      b_reg      <= '0;
      id_reg     <= 1'b0;
      rsp_id_reg <= 1'b0;
      err_reg    <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (take) begin
        op_reg <= gnt[1] ? req1_op : req0_op;
        a_reg  <= gnt[1] ? req1_a  : req0_a;
        b_reg  <= gnt[1] ? req1_b  : req0_b;
        id_reg <= gnt[1];
      end
      // Response fields only change on the EXEC->RESP edge, so they stay
      // stable for the whole RESP stall.
      if (state_reg == ST_EXEC) begin
        rsp_id_reg <= id_reg;
        err_reg    <= exec_illegal;
        result_reg <= exec_illegal ? '0 : alu_result;
      end
    end
  end

  assign rsp_id     = rsp_id_reg;
  assign rsp_err    = err_reg;
  assign rsp_result = result_reg;

endmodule
